// File: rtl/activation_skew_feeder.sv
// -----------------------------------------------------------------------------
// activation_skew_feeder
//
// Upstream stage of a weight-stationary PE array. A job begins with one
// weight-load cycle (mode=0, w_out holding the job's weights). It then accepts
// num_vec activation vectors over valid/ready. Each vector is skewed so that
// row r sees its element r cycles after row 0. done pulses once the last
// skewed element has left the feeder.
//
// Optional build macro: ACT_FEEDER_BUBBLE_CNT_EN
//   When this macro is defined, the output bubble_cnt is added. It counts the
//   STREAM cycles in which the feeder was ready but in_valid was low. It
//   saturates at all-ones.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   job start, sampled in IDLE only
//   num_vec    in   vectors in the job, latched on accepted start
//   w_vec      in   weight lanes, lane r = [r*(WORDWIDTH+1) +: WORDWIDTH+1]
//   in_valid   in   activation vector valid
//   in_ready   out  vector accepted this cycle when in_valid is high
//   in_vec     in   activation lanes, same packing as w_vec
//   mode       out  PE mode: 0 = load weight, 1 = compute
//   w_out      out  registered weight lanes
//   a_out      out  registered skewed activation lanes
//   a_valid    out  per-lane valid for a_out
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle pulse at job end
//   bubble_cnt out  (optional) ready-but-idle STREAM cycle count
// -----------------------------------------------------------------------------
module activation_skew_feeder #(
    parameter int ROWS      = 4,
    parameter int WORDWIDTH = 8,
    parameter int CNTWIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CNTWIDTH-1:0]             num_vec,
    input  logic [ROWS*(WORDWIDTH+1)-1:0]   w_vec,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROWS*(WORDWIDTH+1)-1:0]   in_vec,
    output logic                            mode,
    output logic [ROWS*(WORDWIDTH+1)-1:0]   w_out,
    output logic [ROWS*(WORDWIDTH+1)-1:0]   a_out,
    output logic [ROWS-1:0]                 a_valid,
    output logic                            busy,
    output logic                            done
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
    ,
    output logic [CNTWIDTH-1:0]             bubble_cnt
`endif
);

    localparam int LW = WORDWIDTH + 1;
    localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNTWIDTH-1:0] CNT_ZERO   = {CNTWIDTH{1'b0}};
    localparam logic [CNTWIDTH-1:0] CNT_ONE    = CNTWIDTH'(1);
    // DRAIN lasts ROWS-1 cycles, so the counter runs 0 .. ROWS-2.
    localparam logic [DW-1:0]       DRAIN_LAST = (ROWS > 1) ? DW'(ROWS - 2) : {DW{1'b0}};
    localparam logic [DW-1:0]       DRAIN_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                      state_r;
    state_t                      state_nx_s;
    logic [CNTWIDTH-1:0]         num_r;
    logic [CNTWIDTH-1:0]         acc_cnt_r;
    logic [DW-1:0]               drain_cnt_r;
    logic [ROWS*LW-1:0]          w_out_r;
    logic                        mode_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        in_ready_s;
    logic                        start_ok_s;
    logic                        accept_s;
    logic                        last_acc_s;
    logic                        done_nx_s;

    assign in_ready = in_ready_s;
    assign mode     = mode_r;
    assign w_out    = w_out_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state decode, handshake and end-of-job detection
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = 1'b0;
        start_ok_s = 1'b0;
        accept_s   = 1'b0;
        last_acc_s = 1'b0;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // done_r high means this is the done cycle: a start here is dropped.
                if (start && !done_r) begin
                    start_ok_s = 1'b1;
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (num_r == CNT_ZERO) begin
                    state_nx_s = ST_IDLE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_STREAM;
                end
            end
            ST_STREAM: begin
                in_ready_s = (acc_cnt_r < num_r);
                accept_s   = in_valid && in_ready_s;
                // acc_cnt_r never exceeds num_r-1 here, so no wrap at all-ones.
                last_acc_s = accept_s && (acc_cnt_r == (num_r - CNT_ONE));
                if (last_acc_s) begin
                    if (ROWS == 1) begin
                        state_nx_s = ST_IDLE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = ST_DRAIN;
                    end
                end else begin
                    state_nx_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nx_s = ST_IDLE;
                    done_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register, job bookkeeping and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            num_r       <= CNT_ZERO;
            acc_cnt_r   <= CNT_ZERO;
            drain_cnt_r <= {DW{1'b0}};
            w_out_r     <= {(ROWS*LW){1'b0}};
            mode_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            // Status outputs follow the next state, so they line up with state_r.
            mode_r  <= (state_nx_s != ST_LOAD);
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= done_nx_s;
            if (start_ok_s) begin
                // Weights are captured at start so they are valid during LOAD.
                num_r   <= num_vec;
                w_out_r <= w_vec;
            end
            if (start_ok_s) begin
                acc_cnt_r <= CNT_ZERO;
            end else if (accept_s) begin
                acc_cnt_r <= acc_cnt_r + CNT_ONE;
            end
            drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + DRAIN_ONE) : {DW{1'b0}};
        end
    end

    // Lane r is a shift chain of depth r+1; the last stage drives a_out lane r.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [LW-1:0] data_r [0:r];
        logic          vld_r  [0:r];

        // Shift one element (or a zero bubble) per cycle through this lane
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int j = 0; j <= r; j++) begin
                    data_r[j] <= {LW{1'b0}};
                    vld_r[j]  <= 1'b0;
                end
            end else begin
                data_r[0] <= accept_s ? in_vec[r*LW +: LW] : {LW{1'b0}};
                vld_r[0]  <= accept_s;
                for (int j = 1; j <= r; j++) begin
                    data_r[j] <= data_r[j-1];
                    vld_r[j]  <= vld_r[j-1];
                end
            end
        end

        assign a_out[r*LW +: LW] = data_r[r];
        assign a_valid[r]        = vld_r[r];
    end

`ifdef ACT_FEEDER_BUBBLE_CNT_EN
    localparam logic [CNTWIDTH-1:0] CNT_MAX = {CNTWIDTH{1'b1}};
    logic [CNTWIDTH-1:0] bubble_cnt_r;

    // Saturating count of STREAM cycles that were ready but saw no valid input
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= CNT_ZERO;
        end else if (start_ok_s) begin
            bubble_cnt_r <= CNT_ZERO;
        end else if ((state_r == ST_STREAM) && in_ready_s && !in_valid && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_activation_skew_feeder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for activation_skew_feeder (ROWS=4, WORDWIDTH=8,
// CNTWIDTH=16). Expected lane outputs are pushed to a scoreboard queue when a
// vector is driven into an accepting cycle. The cycle at which each value must
// appear is stored with it. Every cycle, each lane is compared against the
// scoreboard. Control outputs are compared inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_activation_skew_feeder;

    localparam int ROWS = 4;
    localparam int WW   = 8;
    localparam int CW   = 16;
    localparam int LW   = WW + 1;
    localparam logic [LW-1:0] W_VAL = 9'd3;

    typedef struct packed {
        int            cyc;
        int            lane;
        logic [LW-1:0] data;
    } sb_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [CW-1:0]      num_vec = '0;
    logic [ROWS*LW-1:0] w_vec = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ROWS*LW-1:0] in_vec = '0;
    logic               mode;
    logic [ROWS*LW-1:0] w_out;
    logic [ROWS*LW-1:0] a_out;
    logic [ROWS-1:0]    a_valid;
    logic               busy;
    logic               done;
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
    logic [CW-1:0]      bubble_cnt;
`endif

    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    bit  mon_en     = 1'b0;
    sb_t sb_q[$];

    activation_skew_feeder #(.ROWS(ROWS), .WORDWIDTH(WW), .CNTWIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .w_vec     (w_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .mode      (mode),
        .w_out     (w_out),
        .a_out     (a_out),
        .a_valid   (a_valid),
        .busy      (busy),
        .done      (done)
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
        ,
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance one cycle. At the negedge, compare every lane against the
    // scoreboard entries that are due in this cycle.
    task automatic tick();
        logic          exp_v;
        logic [LW-1:0] exp_d;
        int            hit;
        @(negedge clk);
        if (mon_en) begin
            for (int r = 0; r < ROWS; r++) begin
                exp_v = 1'b0;
                exp_d = '0;
                hit   = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (hit < 0 && sb_q[i].lane == r && sb_q[i].cyc == cyc) hit = i;
                end
                if (hit >= 0) begin
                    exp_v = 1'b1;
                    exp_d = sb_q[hit].data;
                    sb_q.delete(hit);
                end
                compared++;
                if (a_valid[r] !== exp_v || a_out[r*LW +: LW] !== exp_d) begin
                    mismatched++;
                    $display("FAIL lane%0d cyc %0d: got valid=%b data=%h, expected valid=%b data=%h",
                             r, cyc, a_valid[r], a_out[r*LW +: LW], exp_v, exp_d);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Run one complete job from IDLE. gap is the STREAM cycle index with in_valid low (-1 for none).
    // spam keeps start high through the job and on the done cycle.
    task automatic drive_job(input int n, input int gap, input bit distinct, input bit spam);
        int            acc;
        int            t;
        logic [LW-1:0] e;
        start   = 1'b1;
        num_vec = CW'(n);
        w_vec   = {ROWS{W_VAL}};
        tick();
        compared++;
        if (mode !== 1'b0 || w_out !== {ROWS{W_VAL}} || busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL load: got mode=%b w_out=%h busy=%b in_ready=%b done=%b, expected 0 %h 1 0 0",
                     mode, w_out, busy, in_ready, done, {ROWS{W_VAL}});
        end
        start = spam;
        tick();
        if (n == 0) begin
            compared++;
            if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || mode !== 1'b1) begin
                mismatched++;
                $display("FAIL zero_done: got done=%b busy=%b in_ready=%b mode=%b, expected 1 0 0 1",
                         done, busy, in_ready, mode);
            end
            start = 1'b0;
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL zero_after: got done=%b busy=%b, expected 0 0", done, busy);
            end
            return;
        end
        acc = 0;
        t   = 0;
        while (acc < n) begin
            compared++;
            if (in_ready !== 1'b1 || mode !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                mismatched++;
                $display("FAIL stream t=%0d: got in_ready=%b mode=%b busy=%b done=%b, expected 1 1 1 0",
                         t, in_ready, mode, busy, done);
            end
            in_valid = (t != gap);
            for (int r = 0; r < ROWS; r++) begin
                e = distinct ? LW'(256 + acc * 16 + r + 1) : LW'(2);
                in_vec[r*LW +: LW] = e;
                if (in_valid) sb_q.push_back('{cyc: cyc + 1 + r, lane: r, data: e});
            end
            if (in_valid) acc++;
            start = spam;
            t++;
            tick();
        end
        in_valid = 1'b0;
        in_vec   = '0;
        for (int k = 0; k < ROWS - 1; k++) begin
            compared++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || mode !== 1'b1) begin
                mismatched++;
                $display("FAIL drain k=%0d: got in_ready=%b busy=%b done=%b mode=%b, expected 0 1 0 1",
                         k, in_ready, busy, done, mode);
            end
            tick();
        end
        compared++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL done_cycle: got done=%b busy=%b in_ready=%b, expected 1 0 0", done, busy, in_ready);
        end
        start = spam;
        tick();
        start = 1'b0;
        compared++;
        if (done !== 1'b0 || busy !== 1'b0 || mode !== 1'b1) begin
            mismatched++;
            $display("FAIL after_done: got done=%b busy=%b mode=%b, expected 0 0 1", done, busy, mode);
        end
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_empty: got %0d pending entries, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        compared++;
        if (mode !== 1'b1 || w_out !== '0 || a_out !== '0 || a_valid !== '0 ||
            in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: got mode=%b w_out=%h a_out=%h a_valid=%b in_ready=%b busy=%b done=%b, expected 1 0 0 0 0 0 0",
                     mode, w_out, a_out, a_valid, in_ready, busy, done);
        end
        reset = 1'b0;
        tick();
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL idle: got busy=%b done=%b in_ready=%b, expected 0 0 0", busy, done, in_ready);
        end
    endtask

    task automatic test_basic();
        drive_job(3, -1, 1'b0, 1'b0);
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
        compared++;
        if (bubble_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL bubble_basic: got %0d, expected 0", bubble_cnt);
        end
`endif
    endtask

    task automatic test_distinct();
        drive_job(5, -1, 1'b1, 1'b0);
    endtask

    task automatic test_bubble();
        drive_job(3, 1, 1'b1, 1'b0);
`ifdef ACT_FEEDER_BUBBLE_CNT_EN
        compared++;
        if (bubble_cnt !== 16'd1) begin
            mismatched++;
            $display("FAIL bubble_cnt: got %0d, expected 1", bubble_cnt);
        end
`endif
    endtask

    task automatic test_zero();
        drive_job(0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_midjob_reset();
        logic [LW-1:0] e;
        start   = 1'b1;
        num_vec = 16'd3;
        w_vec   = {ROWS{W_VAL}};
        tick();
        start = 1'b0;
        tick();
        for (int v = 0; v < 2; v++) begin
            in_valid = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                e = LW'(16 * v + r + 5);
                in_vec[r*LW +: LW] = e;
                sb_q.push_back('{cyc: cyc + 1 + r, lane: r, data: e});
            end
            tick();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        in_vec   = '0;
        tick();
        sb_q.delete();
        compared++;
        if (mode !== 1'b1 || w_out !== '0 || a_out !== '0 || a_valid !== '0 ||
            in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL midjob_reset: got mode=%b w_out=%h a_out=%h a_valid=%b in_ready=%b busy=%b done=%b, expected 1 0 0 0 0 0 0",
                     mode, w_out, a_out, a_valid, in_ready, busy, done);
        end
        reset = 1'b0;
        for (int k = 0; k < ROWS + 1; k++) begin
            tick();
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL post_reset k=%0d: got done=%b busy=%b, expected 0 0", k, done, busy);
            end
        end
        drive_job(3, -1, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        drive_job(3, -1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive_job(2, -1, 1'b1, 1'b0);
        drive_job(4, 2, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_distinct();
        test_bubble();
        test_zero();
        test_midjob_reset();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/activation_skew_feeder.md
Name: activation_skew_feeder

Overview:
- Upstream stage of the weight-stationary PE array: accepts one activation vector per cycle (one element per array row) via valid/ready.
- Skews the vector so row r sees its element r cycles after row 0.
- Sequences the PE mode signal: one weight-load cycle (mode=0), then compute (mode=1).
- Pulses done when the last skewed element has left the feeder.

Parameters:
- ROWS, 4: number of PE rows fed; one output lane per row.
- WORDWIDTH, 8: PE word width; every data lane is WORDWIDTH+1 bits, matching the PE a_in/w_in.
- CNTWIDTH, 16: width of the vector-count register.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a job; sampled only in IDLE.
- num_vec  in  CNTWIDTH  number of activation vectors in the job; latched on accepted start.
- w_vec  in  ROWS*(WORDWIDTH+1)  weights; lane r = bits [r*(WORDWIDTH+1) +: WORDWIDTH+1]; driven to w_out during LOAD.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  feeder accepts vector this cycle.
- in_vec  in  ROWS*(WORDWIDTH+1)  activation vector, same lane packing.
- mode  out  1  PE mode: 0 = load weight, 1 = compute.
- w_out  out  ROWS*(WORDWIDTH+1)  registered weight lanes to the PE rows.
- a_out  out  ROWS*(WORDWIDTH+1)  registered, skewed activation lanes.
- a_valid  out  ROWS  per-lane valid for a_out.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset values: state IDLE; mode=1; w_out=0, a_out=0, a_valid=0; in_ready=0, busy=0, done=0; all skew registers and counters cleared.
- Reset asserted mid-job aborts the job the same cycle. No done pulse is produced.
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE: start=1 latches num_vec and goes to LOAD.
- LOAD: lasts exactly 1 cycle. w_out = w_vec registered, so the PE sees mode=0 with valid weights in the same cycle.
  - Next state is STREAM if latched num_vec>0.
  - If num_vec==0, next state is IDLE with a done pulse on the transition cycle.
- STREAM:
  - in_ready=1 while accepted count < num_vec.
  - Accept = in_valid & in_ready.
  - The accepted element for lane r enters a shift chain of depth r+1. Lane r output appears r+1 cycles after acceptance.
  - Lane 0 has latency 1; lane ROWS-1 has latency ROWS.
  - A cycle without accept inserts a bubble: value 0, valid 0 into every chain. Skew alignment is preserved.
  - When the last vector is accepted, next state is DRAIN and in_ready drops the following cycle.
- DRAIN: chains keep shifting with bubbles for ROWS-1 cycles. Then the FSM returns to IDLE and done pulses on the final DRAIN cycle, coincident with lane ROWS-1 presenting the last valid element.
- mode is 0 only in LOAD and 1 in every other state.
- in_ready is combinational from state/counter only, never from in_valid.
- start while busy is ignored. start on the same cycle as the done pulse is ignored; a new start is sampled in IDLE only.
- a_out lanes are pure pass-through of data; no arithmetic. The count compare is unsigned on CNTWIDTH bits. num_vec = 2^CNTWIDTH-1 must complete without wrap.
- ROWS=1 degenerates to zero DRAIN cycles: done pulses the cycle after the last accept.

Optional Feature:
- Macro: ACT_FEEDER_BUBBLE_CNT_EN.
- Defined: adds output port bubble_cnt (CNTWIDTH).
  - Counts STREAM cycles with in_ready=1 and in_valid=0.
  - Cleared on accepted start and on reset.
  - Saturates at all-ones and holds after done.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then start, num_vec=3, ROWS=4, w_vec lanes={3,3,3,3}, in_valid held 1, in_vec lanes={2,2,2,2}:
  - mode=0 for exactly 1 cycle with w_out lanes=3.
  - Lane r shows a_out=2, a_valid=1 for 3 consecutive cycles starting r+1 cycles after first accept.
  - done pulses 3 cycles after last accept; busy drops the same edge.
- Same job with in_valid low for the 2nd cycle:
  - Every lane shows one a_valid=0 gap at its own skewed position.
  - Total valid count per lane is 3; with the macro, bubble_cnt=1.
- num_vec=0: LOAD cycle only, done pulse, in_ready never asserts, a_valid stays 0.
- Assert reset two cycles into STREAM:
  - Next cycle all outputs are at reset values, no done pulse.
  - A fresh start afterwards completes normally.
- start pulsed during STREAM and on the done cycle: ignored. Accepted count and done timing are unchanged versus the single-start run.
